axil_perip_bridge: RTL and testbench

Converts the datapath's AXI4-Lite data master port into the simple DRAM/peripheral bus: `perip_addr`, `perip_wen`, `perip_mask`, `perip_wdata` and `perip_rdata`. It sits between the core's data interface and the DRAM/peripheral fabric. It replaces ad-hoc read-valid counters with a proper handshake engine that:
- serialises transactions,
- waits a fixed read latency,
- encodes write strobes into the 2-bit peripheral mask,
- returns AXI responses with full backpressure.

---
 rtl/perip_bridge_pkg.sv | 20 ++
 rtl/perip_mask_enc.sv | 33 +++
 rtl/axil_perip_bridge.sv | 138 +++++++++++++
 tb/tb_axil_perip_bridge.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/perip_bridge_pkg.sv
// Shared types and encodings for the AXI4-Lite to peripheral-bus bridge.
package perip_bridge_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_WAIT,
      ST_RD_RESP,
      ST_WR_ISSUE,
      ST_WR_RESP
   } state_t;

   localparam logic [1:0] MASK_BYTE   = 2'b00;
   localparam logic [1:0] MASK_HALF   = 2'b01;
   localparam logic [1:0] MASK_WORD   = 2'b10;
   localparam logic [1:0] MASK_NONE   = 2'b11;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/perip_mask_enc.sv
// Byte-strobe to peripheral size decoder; flags strobe patterns the bus cannot express.
module perip_mask_enc
   import perip_bridge_pkg::*;
(
   input  logic [3:0] strb,
   output logic [1:0] mask,
   output logic       illegal
);

   always_comb begin
      mask    = MASK_NONE;
      illegal = 1'b1;
      case (strb)
         4'b0001, 4'b0010, 4'b0100, 4'b1000: begin
            mask    = MASK_BYTE;
            illegal = 1'b0;
         end
         4'b0011, 4'b1100: begin
            mask    = MASK_HALF;
            illegal = 1'b0;
         end
         4'b1111: begin
            mask    = MASK_WORD;
            illegal = 1'b0;
         end
         default: begin
            mask    = MASK_NONE;
            illegal = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/axil_perip_bridge.sv
// AXI4-Lite slave to DRAM/peripheral bus bridge: one transaction at a time,
// fixed read latency, strobe-to-size encoding, registered outputs throughout.
module axil_perip_bridge
   import perip_bridge_pkg::*;
#(
   parameter int READ_LATENCY = 2,
   parameter int AW           = 32,
   parameter int DW           = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [AW-1:0] s_araddr,
   input  logic          s_arvalid,
   output logic          s_arready,
   output logic [DW-1:0] s_rdata,
   output logic [1:0]    s_rresp,
   output logic          s_rvalid,
   input  logic          s_rready,
   input  logic [AW-1:0] s_awaddr,
   input  logic          s_awvalid,
   output logic          s_awready,
   input  logic [DW-1:0] s_wdata,
   input  logic [3:0]    s_wstrb,
   input  logic          s_wvalid,
   output logic          s_wready,
   output logic [1:0]    s_bresp,
   output logic          s_bvalid,
   input  logic          s_bready,
   output logic [AW-1:0] perip_addr,
   output logic          perip_wen,
   output logic [1:0]    perip_mask,
   output logic [DW-1:0] perip_wdata,
   input  logic [DW-1:0] perip_rdata
);

   state_t     state;
   logic [3:0] cnt;
   logic [1:0] enc_mask;
   logic       enc_illegal;
   logic       wr_pend;
   logic       rd_pend;
   logic       aw_hs;
   logic       ar_hs;

   perip_mask_enc u_mask_enc (
      .strb    (s_wstrb),
      .mask    (enc_mask),
      .illegal (enc_illegal)
   );

   assign wr_pend = s_awvalid & s_wvalid;
   assign rd_pend = s_arvalid & ~wr_pend;
   assign aw_hs   = s_awready & s_wready & wr_pend;
   assign ar_hs   = s_arready & s_arvalid;
   assign s_rresp = RESP_OKAY;

   // Ready flags are registered, so they are computed one edge ahead from the
   // valids seen whenever the next state is IDLE; write has priority.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         s_arready   <= 1'b0;
         s_awready   <= 1'b0;
         s_wready    <= 1'b0;
         s_rvalid    <= 1'b0;
         s_bvalid    <= 1'b0;
         s_rdata     <= '0;
         s_bresp     <= RESP_OKAY;
         perip_addr  <= '0;
         perip_wen   <= 1'b0;
         perip_mask  <= MASK_NONE;
         perip_wdata <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (aw_hs) begin
                  s_awready   <= 1'b0;
                  s_wready    <= 1'b0;
                  s_arready   <= 1'b0;
                  perip_addr  <= s_awaddr;
                  perip_wdata <= s_wdata;
                  perip_wen   <= ~enc_illegal;
                  perip_mask  <= enc_illegal ? MASK_NONE : enc_mask;
                  s_bresp     <= enc_illegal ? RESP_SLVERR : RESP_OKAY;
                  state       <= ST_WR_ISSUE;
               end else if (ar_hs) begin
                  s_awready  <= 1'b0;
                  s_wready   <= 1'b0;
                  s_arready  <= 1'b0;
                  perip_addr <= s_araddr;
                  cnt        <= 4'(READ_LATENCY);
                  state      <= ST_RD_WAIT;
               end else begin
                  s_awready <= wr_pend;
                  s_wready  <= wr_pend;
                  s_arready <= rd_pend;
               end
            end
            ST_RD_WAIT: begin
               if (cnt == 4'd1) begin
                  s_rdata  <= perip_rdata;
                  s_rvalid <= 1'b1;
                  state    <= ST_RD_RESP;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            ST_RD_RESP: begin
               if (s_rready) begin
                  s_rvalid  <= 1'b0;
                  s_awready <= wr_pend;
                  s_wready  <= wr_pend;
                  s_arready <= rd_pend;
                  state     <= ST_IDLE;
               end
            end
            ST_WR_ISSUE: begin
               perip_wen  <= 1'b0;
               perip_mask <= MASK_NONE;
               s_bvalid   <= 1'b1;
               state      <= ST_WR_RESP;
            end
            ST_WR_RESP: begin
               if (s_bready) begin
                  s_bvalid  <= 1'b0;
                  s_awready <= wr_pend;
                  s_wready  <= wr_pend;
                  s_arready <= rd_pend;
                  state     <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axil_perip_bridge.sv
// Directed bench for axil_perip_bridge: reads, writes, strobe encoding,
// arbitration, response backpressure and mid-transaction reset.
module tb_axil_perip_bridge;
   import perip_bridge_pkg::*;

   localparam int RL = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] s_araddr;
   logic        s_arvalid;
   logic        s_arready;
   logic [31:0] s_rdata;
   logic [1:0]  s_rresp;
   logic        s_rvalid;
   logic        s_rready;
   logic [31:0] s_awaddr;
   logic        s_awvalid;
   logic        s_awready;
   logic [31:0] s_wdata;
   logic [3:0]  s_wstrb;
   logic        s_wvalid;
   logic        s_wready;
   logic [1:0]  s_bresp;
   logic        s_bvalid;
   logic        s_bready;
   logic [31:0] perip_addr;
   logic        perip_wen;
   logic [1:0]  perip_mask;
   logic [31:0] perip_wdata;
   logic [31:0] perip_rdata;

   int total  = 0;
   int passed = 0;
   int fails  = 0;

   axil_perip_bridge #(.READ_LATENCY(RL), .AW(32), .DW(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .s_araddr    (s_araddr),
      .s_arvalid   (s_arvalid),
      .s_arready   (s_arready),
      .s_rdata     (s_rdata),
      .s_rresp     (s_rresp),
      .s_rvalid    (s_rvalid),
      .s_rready    (s_rready),
      .s_awaddr    (s_awaddr),
      .s_awvalid   (s_awvalid),
      .s_awready   (s_awready),
      .s_wdata     (s_wdata),
      .s_wstrb     (s_wstrb),
      .s_wvalid    (s_wvalid),
      .s_wready    (s_wready),
      .s_bresp     (s_bresp),
      .s_bvalid    (s_bvalid),
      .s_bready    (s_bready),
      .perip_addr  (perip_addr),
      .perip_wen   (perip_wen),
      .perip_mask  (perip_mask),
      .perip_wdata (perip_wdata),
      .perip_rdata (perip_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, " readys"}, {29'd0, s_arready, s_awready, s_wready}, 32'd0);
      chk({tag, " valids"}, {30'd0, s_rvalid, s_bvalid}, 32'd0);
      chk({tag, " wen"}, {31'd0, perip_wen}, 32'd0);
      chk({tag, " mask"}, {30'd0, perip_mask}, 32'd3);
      chk({tag, " addr"}, perip_addr, 32'd0);
      chk({tag, " wdata"}, perip_wdata, 32'd0);
      chk({tag, " rdata"}, s_rdata, 32'd0);
      chk({tag, " resps"}, {28'd0, s_rresp, s_bresp}, 32'd0);
   endtask

   task automatic do_read(input string tag, input logic [31:0] addr,
                          input logic [31:0] data, input int stall);
      int n = 0;
      s_araddr  = addr;
      s_arvalid = 1'b1;
      s_rready  = (stall == 0);
      while (s_arready !== 1'b1 && n < 8) begin
         sample();
         n++;
      end
      chk({tag, " ar_accept"}, {31'd0, s_arready}, 32'd1);
      tick();
      s_arvalid   = 1'b0;
      perip_rdata = 32'h0BAD_0BAD;
      for (int i = 0; i < RL; i++) begin
         if (i == RL - 1) perip_rdata = data;
         sample();
         chk({tag, " addr_held"}, perip_addr, addr);
         chk({tag, " rvalid_early"}, {31'd0, s_rvalid}, 32'd0);
         chk({tag, " arready_busy"}, {31'd0, s_arready}, 32'd0);
         tick();
      end
      perip_rdata = 32'h0BAD_0BAD;
      sample();
      chk({tag, " rvalid"}, {31'd0, s_rvalid}, 32'd1);
      chk({tag, " rdata"}, s_rdata, data);
      chk({tag, " rresp"}, {30'd0, s_rresp}, 32'd0);
      if (stall > 0) begin
         s_araddr  = 32'h2000_0004;
         s_arvalid = 1'b1;
         for (int i = 0; i < stall; i++) begin
            tick();
            sample();
            chk({tag, " bp_rvalid"}, {31'd0, s_rvalid}, 32'd1);
            chk({tag, " bp_rdata"}, s_rdata, data);
            chk({tag, " bp_arready"}, {31'd0, s_arready}, 32'd0);
         end
      end
      s_rready = 1'b1;
      tick();
      sample();
      chk({tag, " rvalid_done"}, {31'd0, s_rvalid}, 32'd0);
   endtask

   task automatic do_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic exp_wen,
                           input logic [1:0] exp_mask, input logic [1:0] exp_bresp);
      int n = 0;
      s_awaddr  = addr;
      s_wdata   = data;
      s_wstrb   = strb;
      s_awvalid = 1'b1;
      s_wvalid  = 1'b1;
      s_bready  = 1'b1;
      while (s_awready !== 1'b1 && n < 8) begin
         sample();
         n++;
      end
      chk({tag, " aw_accept"}, {31'd0, s_awready}, 32'd1);
      chk({tag, " w_accept"}, {31'd0, s_wready}, 32'd1);
      tick();
      s_awvalid = 1'b0;
      s_wvalid  = 1'b0;
      sample();
      chk({tag, " wen"}, {31'd0, perip_wen}, {31'd0, exp_wen});
      chk({tag, " mask"}, {30'd0, perip_mask}, {30'd0, exp_mask});
      chk({tag, " bvalid_early"}, {31'd0, s_bvalid}, 32'd0);
      if (exp_wen) begin
         chk({tag, " addr"}, perip_addr, addr);
         chk({tag, " wdata"}, perip_wdata, data);
      end
      tick();
      sample();
      chk({tag, " wen_off"}, {31'd0, perip_wen}, 32'd0);
      chk({tag, " mask_off"}, {30'd0, perip_mask}, 32'd3);
      chk({tag, " bvalid"}, {31'd0, s_bvalid}, 32'd1);
      chk({tag, " bresp"}, {30'd0, s_bresp}, {30'd0, exp_bresp});
      tick();
      sample();
      chk({tag, " bvalid_done"}, {31'd0, s_bvalid}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst         = 1'b0;
      s_araddr    = '0;
      s_arvalid   = 1'b0;
      s_rready    = 1'b0;
      s_awaddr    = '0;
      s_awvalid   = 1'b0;
      s_wdata     = '0;
      s_wstrb     = '0;
      s_wvalid    = 1'b0;
      s_bready    = 1'b0;
      perip_rdata = 32'h0BAD_0BAD;

      repeat (2) sample();
      chk_reset_vals("reset");
      tick();
      rst = 1'b1;
      sample();

      do_read("rd1", 32'h8000_0010, 32'hDEAD_BEEF, 0);

      do_write("wr_word", 32'h0000_0100, 32'h1234_5678, 4'b1111, 1'b1, MASK_WORD, RESP_OKAY);
      do_write("wr_byte", 32'h0000_0104, 32'hAABB_CCDD, 4'b0100, 1'b1, MASK_BYTE, RESP_OKAY);
      do_write("wr_half", 32'h0000_0108, 32'h1122_3344, 4'b1100, 1'b1, MASK_HALF, RESP_OKAY);
      do_write("wr_bad",  32'h0000_010C, 32'h5566_7788, 4'b0101, 1'b0, MASK_NONE, RESP_SLVERR);
      do_write("wr_zero", 32'h0000_0110, 32'h99AA_BBCC, 4'b0000, 1'b0, MASK_NONE, RESP_SLVERR);

      do_read("rd_bp", 32'h3000_0000, 32'hCAFE_F00D, 5);
      chk("rd_bp next_ar", {31'd0, s_arready}, 32'd1);
      do_read("rd2", 32'h2000_0004, 32'h1357_9BDF, 0);

      // Read and write requested together from IDLE.
      s_araddr  = 32'h4000_0008;
      s_arvalid = 1'b1;
      s_awaddr  = 32'h0000_0200;
      s_wdata   = 32'hA5A5_A5A5;
      s_wstrb   = 4'b1111;
      s_awvalid = 1'b1;
      s_wvalid  = 1'b1;
      s_bready  = 1'b1;
      s_rready  = 1'b1;
      sample();
      chk("arb awready", {31'd0, s_awready}, 32'd1);
      chk("arb arready", {31'd0, s_arready}, 32'd0);
      tick();
      s_awvalid = 1'b0;
      s_wvalid  = 1'b0;
      sample();
      chk("arb wen", {31'd0, perip_wen}, 32'd1);
      chk("arb waddr", perip_addr, 32'h0000_0200);
      chk("arb ar_blocked1", {31'd0, s_arready}, 32'd0);
      tick();
      sample();
      chk("arb bvalid", {31'd0, s_bvalid}, 32'd1);
      chk("arb ar_blocked2", {31'd0, s_arready}, 32'd0);
      tick();
      sample();
      chk("arb bdone", {31'd0, s_bvalid}, 32'd0);
      chk("arb ar_after_b", {31'd0, s_arready}, 32'd1);
      do_read("arb_rd", 32'h4000_0008, 32'h0246_8ACE, 0);

      // Reset while waiting on read data.
      s_araddr  = 32'h5000_0000;
      s_arvalid = 1'b1;
      sample();
      chk("rst_rd arready", {31'd0, s_arready}, 32'd1);
      tick();
      s_arvalid = 1'b0;
      #2;
      chk("rst_rd addr_before", perip_addr, 32'h5000_0000);
      rst = 1'b0;
      #1;
      chk_reset_vals("rst_rd");
      tick();
      rst = 1'b1;
      repeat (RL + 3) begin
         sample();
         chk("rst_rd no_rvalid", {31'd0, s_rvalid}, 32'd0);
      end

      // Reset during the peripheral write pulse.
      s_awaddr  = 32'h0000_0300;
      s_wdata   = 32'h7777_8888;
      s_wstrb   = 4'b0011;
      s_awvalid = 1'b1;
      s_wvalid  = 1'b1;
      sample();
      chk("rst_wr awready", {31'd0, s_awready}, 32'd1);
      tick();
      s_awvalid = 1'b0;
      s_wvalid  = 1'b0;
      #2;
      chk("rst_wr wen_before", {31'd0, perip_wen}, 32'd1);
      rst = 1'b0;
      #1;
      chk_reset_vals("rst_wr");
      tick();
      rst = 1'b1;
      repeat (4) begin
         sample();
         chk("rst_wr no_bvalid", {31'd0, s_bvalid}, 32'd0);
         chk("rst_wr no_wen", {31'd0, perip_wen}, 32'd0);
      end

      do_read("rd_fresh", 32'h6000_0020, 32'h0F0F_0F0F, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
